// File: rtl/nonce_sched_if.sv
// Host work/result, pipeline issue and compare-stage signals of the nonce scheduler.
// slave is the scheduler side; master is the host/pipeline side.
interface nonce_sched_if;
    logic        work_valid;
    logic        work_ready;
    logic [31:0] work_start;
    logic [31:0] work_count;
    logic [63:0] work_target;
    logic        abort;
    logic        core_hold;
    logic        issue_valid;
    logic [31:0] issue_nonce;
    logic [63:0] target;
    logic        cmp_valid;
    logic        cmp_found;
    logic [31:0] cmp_nonce;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_status;
    logic [31:0] res_nonce;
    logic        busy;
    logic [47:0] hash_cnt;

    modport slave (
        input  work_valid, work_start, work_count, work_target, abort, core_hold,
               cmp_valid, cmp_found, cmp_nonce, res_ready,
        output work_ready, issue_valid, issue_nonce, target, res_valid, res_status,
               res_nonce, busy, hash_cnt
    );

    modport master (
        output work_valid, work_start, work_count, work_target, abort, core_hold,
               cmp_valid, cmp_found, cmp_nonce, res_ready,
        input  work_ready, issue_valid, issue_nonce, target, res_valid, res_status,
               res_nonce, busy, hash_cnt
    );
endinterface

// File: rtl/nonce_sched.sv
// Work controller for the blake2b pipeline: issues one nonce per cycle, tracks
// in-flight results and returns one result record per work item.
module nonce_sched #(
    parameter int unsigned PIPE_DEPTH = 128,
    parameter int unsigned INFL_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    nonce_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REPORT} state_t;

    localparam logic [1:0]        ST_FOUND = 2'b01;
    localparam logic [1:0]        ST_EXH   = 2'b10;
    localparam logic [1:0]        ST_ABORT = 2'b11;
    localparam logic [INFL_W-1:0] DEPTH    = INFL_W'(PIPE_DEPTH);

    state_t            r_state, w_state_n;
    logic [31:0]       r_cur, w_cur_n;
    logic [32:0]       r_rem, w_rem_n;
    logic [INFL_W-1:0] r_infl, w_infl_n;
    logic              r_hit, w_hit_n;
    logic              r_abt, w_abt_n;
    logic [31:0]       r_hit_nonce, w_hit_nonce_n;
    logic [63:0]       r_target, w_target_n;
    logic              r_issue_valid;
    logic [31:0]       r_issue_nonce, w_issue_nonce_n;
    logic              r_res_valid, w_res_valid_n;
    logic [1:0]        r_res_status, w_res_status_n;
    logic [31:0]       r_res_nonce, w_res_nonce_n;
    logic [47:0]       r_hash_cnt, w_hash_cnt_n;
    logic              r_work_ready;
    logic              r_busy;
    logic              w_active, w_hit, w_abort, w_retire, w_issue;

    always_comb begin
        w_active = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        w_hit    = w_active && bus.cmp_valid && bus.cmp_found && !r_hit;
        w_abort  = w_active && bus.abort && !r_hit && !w_hit;
        w_retire = bus.cmp_valid && (r_infl != '0);
        // A hit or abort seen this cycle suppresses the issue so nothing new enters after the stop.
        w_issue  = (r_state == S_ISSUE) && !bus.core_hold && (r_infl < DEPTH) && !w_hit && !bus.abort;

        w_state_n       = r_state;
        w_cur_n         = r_cur;
        w_rem_n         = r_rem;
        w_hit_n         = r_hit;
        w_abt_n         = r_abt;
        w_hit_nonce_n   = r_hit_nonce;
        w_target_n      = r_target;
        w_issue_nonce_n = r_issue_nonce;
        w_res_valid_n   = r_res_valid;
        w_res_status_n  = r_res_status;
        w_res_nonce_n   = r_res_nonce;
        w_hash_cnt_n    = r_hash_cnt;

        if (w_issue) begin
            w_issue_nonce_n = r_cur;
            w_cur_n         = r_cur + 32'd1;
            w_rem_n         = r_rem - 33'd1;
            w_hash_cnt_n    = r_hash_cnt + 48'd1;
        end
        w_infl_n = r_infl + INFL_W'(w_issue) - INFL_W'(w_retire);

        if (w_hit) begin
            w_hit_n       = 1'b1;
            w_hit_nonce_n = bus.cmp_nonce;
        end
        if (w_abort) begin
            w_abt_n = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.work_valid) begin
                    w_state_n     = S_ISSUE;
                    w_cur_n       = bus.work_start;
                    w_rem_n       = (bus.work_count == '0) ? 33'h1_0000_0000 : {1'b0, bus.work_count};
                    w_target_n    = bus.work_target;
                    w_hit_n       = 1'b0;
                    w_abt_n       = 1'b0;
                    w_hit_nonce_n = '0;
                end
            end
            S_ISSUE: begin
                if (w_hit || w_abort || (w_issue && (r_rem == 33'd1))) begin
                    w_state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_infl == '0) begin
                    w_state_n      = S_REPORT;
                    w_res_valid_n  = 1'b1;
                    w_res_status_n = w_hit_n ? ST_FOUND : (w_abt_n ? ST_ABORT : ST_EXH);
                    w_res_nonce_n  = w_hit_n ? w_hit_nonce_n : '0;
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    w_state_n     = S_IDLE;
                    w_res_valid_n = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_rem         <= '0;
            r_infl        <= '0;
            r_hit         <= 1'b0;
            r_abt         <= 1'b0;
            r_hit_nonce   <= '0;
            r_target      <= '0;
            r_issue_valid <= 1'b0;
            r_issue_nonce <= '0;
            r_res_valid   <= 1'b0;
            r_res_status  <= '0;
            r_res_nonce   <= '0;
            r_hash_cnt    <= '0;
            r_work_ready  <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_cur         <= w_cur_n;
            r_rem         <= w_rem_n;
            r_infl        <= w_infl_n;
            r_hit         <= w_hit_n;
            r_abt         <= w_abt_n;
            r_hit_nonce   <= w_hit_nonce_n;
            r_target      <= w_target_n;
            r_issue_valid <= w_issue;
            r_issue_nonce <= w_issue_nonce_n;
            r_res_valid   <= w_res_valid_n;
            r_res_status  <= w_res_status_n;
            r_res_nonce   <= w_res_nonce_n;
            r_hash_cnt    <= w_hash_cnt_n;
            r_work_ready  <= (w_state_n == S_IDLE);
            r_busy        <= (w_state_n != S_IDLE);
        end
    end

    assign bus.work_ready  = r_work_ready;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_nonce = r_issue_nonce;
    assign bus.target      = r_target;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_status  = r_res_status;
    assign bus.res_nonce   = r_res_nonce;
    assign bus.busy        = r_busy;
    assign bus.hash_cnt    = r_hash_cnt;
endmodule

// File: tb/tb_nonce_sched.sv
// Directed bench for nonce_sched with a fixed-latency pipeline/compare model.
module tb_nonce_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;

    nonce_sched_if bus();

    nonce_sched #(.PIPE_DEPTH(4), .INFL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] n; int unsigned due; } ent_t;
    ent_t            q[$];
    logic [31:0]     iss_log[$];
    int unsigned     iss_cyc[$];
    int unsigned     cyc = 0, n_iss = 0, post_hit = 0, lat = 3;
    bit              pipe_en = 1'b1, hit_en = 1'b0, hit_seen = 1'b0;
    logic [31:0]     hit_lo = '0, hit_hi = '0;
    int              n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pipeline + compare model: records every issued nonce, returns it lat cycles later.
    always @(negedge clk) begin : model
        ent_t e;
        cyc++;
        if (!rst) begin
            q.delete();
            bus.cmp_valid = 1'b0;
            bus.cmp_found = 1'b0;
            bus.cmp_nonce = '0;
        end else begin
            if (bus.issue_valid) begin
                q.push_back('{n: bus.issue_nonce, due: cyc + lat});
                iss_log.push_back(bus.issue_nonce);
                iss_cyc.push_back(cyc);
                n_iss++;
                if (hit_seen) post_hit++;
            end
            bus.cmp_valid = 1'b0;
            bus.cmp_found = 1'b0;
            bus.cmp_nonce = '0;
            if (pipe_en && q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                bus.cmp_valid = 1'b1;
                bus.cmp_nonce = e.n;
                bus.cmp_found = hit_en && (e.n >= hit_lo) && (e.n <= hit_hi);
                if (bus.cmp_found) hit_seen = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_log.delete();
        iss_cyc.delete();
        n_iss    = 0;
        post_hit = 0;
        hit_seen = 1'b0;
    endtask

    task automatic start_work(input logic [31:0] s, input logic [31:0] c, input logic [63:0] t,
                              output int unsigned acc);
        check("acc_ready", bus.work_ready, 1);
        bus.work_start  = s;
        bus.work_count  = c;
        bus.work_target = t;
        bus.work_valid  = 1'b1;
        tick();
        bus.work_valid  = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_res(input string tag, input int unsigned max);
        for (int unsigned i = 0; i < max; i++) begin
            if (bus.res_valid) break;
            tick();
        end
        check(tag, bus.res_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        logic        stable;
        logic        seen;
        logic [31:0] exp3 [4];

        bus.work_valid = 1'b0; bus.work_start = '0; bus.work_count = '0; bus.work_target = '0;
        bus.abort = 1'b0; bus.core_hold = 1'b0; bus.res_ready = 1'b1;

        #2 rst = 1'b0;
        #1;
        check("rst_work_ready", bus.work_ready, 1);
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_hash_cnt", bus.hash_cnt, 0);
        check("rst_target", bus.target, 0);
        check("rst_res_status", bus.res_status, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Exhaustion of a short range, long pipeline latency.
        lat = 96; clear_logs();
        start_work(32'h10, 32'd4, 64'h0123_4567_89ab_cdef, acc);
        check("t1_busy", bus.busy, 1);
        check("t1_target", bus.target, 64'h0123_4567_89ab_cdef);
        wait_res("t1_res", 400);
        check("t1_status", bus.res_status, 2'b10);
        check("t1_res_nonce", bus.res_nonce, 0);
        check("t1_hash_cnt", bus.hash_cnt, 4);
        check("t1_n_iss", n_iss, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_nonce", iss_log[i], 32'h10 + i);
            check("t1_cyc", iss_cyc[i], acc + 1 + i);
        end
        tick();

        // First hit at 0x25 wins; later hits during drain are ignored.
        lat = 3; clear_logs(); hit_en = 1'b1; hit_lo = 32'h25; hit_hi = 32'hFFFF_FFFF;
        start_work(32'h20, 32'd1000, 64'h0000_ffff_ffff_ffff, acc);
        wait_res("t2_res", 500);
        check("t2_status", bus.res_status, 2'b01);
        check("t2_res_nonce", bus.res_nonce, 32'h25);
        check("t2_stop", post_hit <= 1, 1);
        check("t2_drained", q.size(), 0);
        tick();
        hit_en = 1'b0;

        // Nonce wrap at the top of the 32-bit range.
        lat = 5; clear_logs();
        exp3 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        start_work(32'hFFFF_FFFE, 32'd4, 64'h55, acc);
        wait_res("t3_res", 200);
        check("t3_status", bus.res_status, 2'b10);
        check("t3_n_iss", n_iss, 4);
        for (int i = 0; i < 4; i++) check("t3_nonce", iss_log[i], exp3[i]);
        tick();

        // count=0 means 2^32; abort after exactly 50 issues.
        lat = 3; clear_logs();
        start_work(32'h1000, 32'd0, 64'h77, acc);
        for (int i = 0; i < 2000 && n_iss < 50; i++) tick();
        check("t4_reach50", n_iss, 50);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_res("t4_res", 200);
        check("t4_n_iss", n_iss, 50);
        check("t4_status", bus.res_status, 2'b11);
        check("t4_res_nonce", bus.res_nonce, 0);
        tick();

        // core_hold gates issue; in-flight limit stalls at PIPE_DEPTH with no results.
        lat = 5; clear_logs(); pipe_en = 1'b0; bus.core_hold = 1'b1;
        start_work(32'h500, 32'd100, 64'hAA, acc);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold", bus.issue_valid, 0);
        end
        check("t5_hold_cnt", n_iss, 0);
        bus.core_hold = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t5_stall_cnt", n_iss, 4);
        check("t5_target", bus.target, 64'hAA);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        pipe_en = 1'b1;
        wait_res("t5_res", 200);
        check("t5_status", bus.res_status, 2'b11);
        tick();

        // Asynchronous reset in the middle of issuing.
        lat = 3; clear_logs();
        start_work(32'h900, 32'd1000, 64'hBB, acc);
        for (int i = 0; i < 5; i++) tick();
        check("t6_busy_pre", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("t6_issue_valid", bus.issue_valid, 0);
        check("t6_issue_nonce", bus.issue_nonce, 0);
        check("t6_work_ready", bus.work_ready, 1);
        check("t6_busy", bus.busy, 0);
        check("t6_hash_cnt", bus.hash_cnt, 0);
        check("t6_target", bus.target, 0);
        check("t6_res_valid", bus.res_valid, 0);
        tick(); tick();
        rst = 1'b1;
        clear_logs();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.res_valid) seen = 1'b1;
        end
        check("t6_no_res", seen, 0);
        check("t6_no_issue", n_iss, 0);
        check("t6_ready_after", bus.work_ready, 1);

        // Result held stable while the host stalls res_ready.
        lat = 3; clear_logs(); hit_en = 1'b1; hit_lo = 32'h41; hit_hi = 32'h41;
        bus.res_ready = 1'b0;
        start_work(32'h40, 32'd3, 64'hCC, acc);
        wait_res("t7_res", 200);
        check("t7_status", bus.res_status, 2'b01);
        check("t7_res_nonce", bus.res_nonce, 32'h41);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(bus.res_valid && bus.res_status == 2'b01 && bus.res_nonce == 32'h41 && bus.busy))
                stable = 1'b0;
        end
        check("t7_stable", stable, 1);
        bus.res_ready = 1'b1;
        tick();
        check("t7_res_valid_clr", bus.res_valid, 0);
        check("t7_work_ready", bus.work_ready, 1);
        check("t7_busy", bus.busy, 0);
        hit_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
